// File: rtl/count_event_monitor_pkg.sv
// count_event_monitor_pkg
// Shared definitions for the count event monitor slice.
//   state_t      : monitor FSM encoding (INIT / TRACK / FAULT)
//   FILL_TARGET  : number of post-reset cycles needed before the
//                  synchronizer output is trusted
package count_event_monitor_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FILL_TARGET = 2'd2;

endpackage

// File: rtl/count_sync.sv
// count_sync
// Brings the asynchronous ripple-counter value into the clk domain.
// Optional glitch filter: define COUNT_EVENT_MONITOR_GLITCH_FILTER_EN to add
// a third stage and only accept a sample once it has been stable for two
// consecutive clk samples.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   cnt_in   in   raw count from the ripple counter (asynchronous)
//   cand     out  synchronized candidate count (second stage)
//   accept   out  candidate may be consumed this cycle
module count_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cand,
    output logic             accept
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Classic two-flop synchronizer. Individual bits may resolve on
    // different cycles while the ripple settles, so the downstream logic
    // must tolerate (or filter) a transiently wrong multi-bit value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
        end
    end

    assign cand = s2;

`ifdef COUNT_EVENT_MONITOR_GLITCH_FILTER_EN
    logic [WIDTH-1:0] s3;

    // Extra delay stage used only for the stability comparison. A ripple
    // transient that lasts a single sample never matches its neighbour and
    // therefore never gets accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3 <= '0;
        end else begin
            s3 <= s2;
        end
    end

    assign accept = (s2 == s3);
`else
    // Without the filter every synchronized sample is taken as-is; this is
    // meant for an upstream counter that is already glitch-free.
    assign accept = 1'b1;
`endif

endmodule

// File: rtl/count_event_monitor.sv
// count_event_monitor
// Watches the synchronized output of a ripple counter, checks that it only
// ever advances by one, and produces wrap / compare-match pulses, an
// extended wrap count and a sticky sequence-error flag.
// Optional glitch filter in the synchronizer: COUNT_EVENT_MONITOR_GLITCH_FILTER_EN.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cnt_in       in   raw ripple count (asynchronous)
//   cmp_val      in   compare value
//   cmp_en       in   enables match_pulse
//   err_clr      in   clears seq_err and leaves FAULT
//   cnt_q        out  last accepted count
//   wrap_pulse   out  one-cycle pulse on an accepted max->0 step
//   match_pulse  out  one-cycle pulse when a new value equals cmp_val
//   wrap_count   out  number of wraps, modulo 2^EXT_W
//   seq_err      out  sticky sequence-error flag
module count_event_monitor
    import count_event_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int EXT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             cmp_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] cnt_q,
    output logic             wrap_pulse,
    output logic             match_pulse,
    output logic [EXT_W-1:0] wrap_count,
    output logic             seq_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cand;
    logic             accept;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       fill_cnt;
    logic [1:0]       fill_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [EXT_W-1:0] wrap_count_nxt;
    logic             wrap_nxt;
    logic             match_nxt;
    logic             err_nxt;

    logic [WIDTH-1:0] cnt_inc;
    logic             is_same;
    logic             is_succ;
    logic             is_bad;

    count_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .cnt_in  (cnt_in),
        .cand    (cand),
        .accept  (accept)
    );

    // Classification of the candidate against the last accepted count.
    // The successor is computed modulo 2^WIDTH so max->0 counts as a
    // legal step. "Bad" means an accepted value that is neither a hold
    // nor a +1 step.
    assign cnt_inc = cnt_q + WIDTH'(1);
    assign is_same = (cand == cnt_q);
    assign is_succ = (cand == cnt_inc);
    assign is_bad  = accept && !is_same && !is_succ;

    // Next-state and next-output logic. Pulses default low every cycle so
    // they can never stretch, even with back-to-back increments.
    // INIT waits for the fill counter before trusting the synchronizer and
    // then loads cnt_q silently. The fill counter is only rerun by reset,
    // so leaving FAULT reloads on the very next accepted candidate.
    // In FAULT a fresh bad step blocks err_clr so the error is never lost.
    always_comb begin
        state_nxt      = state;
        fill_nxt       = fill_cnt;
        cnt_nxt        = cnt_q;
        wrap_count_nxt = wrap_count;
        wrap_nxt       = 1'b0;
        match_nxt      = 1'b0;
        err_nxt        = seq_err;

        case (state)
            ST_INIT: begin
                if (fill_cnt != FILL_TARGET) begin
                    fill_nxt = fill_cnt + 2'd1;
                end else if (accept) begin
                    cnt_nxt   = cand;
                    state_nxt = ST_TRACK;
                end
            end

            ST_TRACK: begin
                if (accept && !is_same) begin
                    cnt_nxt = cand;
                    if (is_succ) begin
                        if (cnt_q == CNT_MAX) begin
                            wrap_nxt       = 1'b1;
                            wrap_count_nxt = wrap_count + EXT_W'(1);
                        end
                        if (cmp_en && (cand == cmp_val)) begin
                            match_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_FAULT;
                    end
                end
            end

            ST_FAULT: begin
                if (accept) begin
                    cnt_nxt = cand;
                end
                if (err_clr && !is_bad) begin
                    err_nxt   = 1'b0;
                    state_nxt = ST_INIT;
                end
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // State and output registers. Everything returns to zero / INIT the
    // moment reset_n falls, independent of the clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            fill_cnt    <= 2'd0;
            cnt_q       <= '0;
            wrap_count  <= '0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill_cnt    <= fill_nxt;
            cnt_q       <= cnt_nxt;
            wrap_count  <= wrap_count_nxt;
            wrap_pulse  <= wrap_nxt;
            match_pulse <= match_nxt;
            seq_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor
// Self-checking bench for count_event_monitor. A behavioural model tracks
// the input history and applies the monitor's rules with plain arithmetic;
// every cycle the DUT outputs are compared against it, and directed steps
// add explicit checks for the interesting corners.
// Honours COUNT_EVENT_MONITOR_GLITCH_FILTER_EN the same way as the design.
module tb_count_event_monitor;

`ifdef COUNT_EVENT_MONITOR_GLITCH_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif
    localparam int LAT  = FILTER ? 3 : 2;
    localparam int MINH = FILTER ? 2 : 1;

    localparam int M_INIT  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cnt_in;
    logic [3:0] cmp_val;
    logic       cmp_en;
    logic       err_clr;
    logic [3:0] cnt_q;
    logic       wrap_pulse;
    logic       match_pulse;
    logic [7:0] wrap_count;
    logic       seq_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int wp_seen = 0;
    int mp_seen = 0;

    int m_mode;
    int m_fill;
    int m_cnt;
    int m_wraps;
    bit m_err;
    bit m_wp;
    bit m_mp;
    int hist[$];

    count_event_monitor #(
        .WIDTH (4),
        .EXT_W (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cnt_in      (cnt_in),
        .cmp_val     (cmp_val),
        .cmp_en      (cmp_en),
        .err_clr     (err_clr),
        .cnt_q       (cnt_q),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse),
        .wrap_count  (wrap_count),
        .seq_err     (seq_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        m_mode  = M_INIT;
        m_fill  = 0;
        m_cnt   = 0;
        m_wraps = 0;
        m_err   = 1'b0;
        m_wp    = 1'b0;
        m_mp    = 1'b0;
        hist    = {0, 0, 0};
    endtask

    // One clock edge of the reference: the candidate is the input seen two
    // edges ago; with the filter it must also equal the input three edges ago.
    task automatic modelStep();
        int v;
        int diff;
        bit acc;
        bit bad;
        if (!reset_n) begin
            modelReset();
            return;
        end
        v    = hist[hist.size()-2];
        acc  = FILTER ? (hist[hist.size()-2] == hist[hist.size()-3]) : 1'b1;
        diff = (v - m_cnt + 16) % 16;
        m_wp = 1'b0;
        m_mp = 1'b0;
        case (m_mode)
            M_INIT: begin
                if (m_fill < 2) m_fill++;
                else if (acc) begin
                    m_cnt  = v;
                    m_mode = M_TRACK;
                end
            end
            M_TRACK: begin
                if (acc && diff != 0) begin
                    if (diff == 1) begin
                        if (m_cnt == 15) begin
                            m_wp    = 1'b1;
                            m_wraps = (m_wraps + 1) % 256;
                        end
                        if (cmp_en && v == int'(cmp_val)) m_mp = 1'b1;
                    end else begin
                        m_err  = 1'b1;
                        m_mode = M_FAULT;
                    end
                    m_cnt = v;
                end
            end
            default: begin
                bad = acc && diff > 1;
                if (acc) m_cnt = v;
                if (err_clr && !bad) begin
                    m_err  = 1'b0;
                    m_mode = M_INIT;
                end
            end
        endcase
        hist.push_back(int'(cnt_in));
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic checkAll();
        checkOutput("cnt_q", 32'(cnt_q), m_cnt);
        checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
        checkOutput("match_pulse", 32'(match_pulse), 32'(m_mp));
        checkOutput("wrap_count", 32'(wrap_count), m_wraps);
        checkOutput("seq_err", 32'(seq_err), 32'(m_err));
        wp_seen += int'(wrap_pulse);
        mp_seen += int'(match_pulse);
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] cv,
                                 input logic ce, input logic clr, input int n);
        cnt_in  = c;
        cmp_val = cv;
        cmp_en  = ce;
        err_clr = clr;
        repeat (n) begin
            @(posedge clk);
            modelStep();
            #1;
            checkAll();
        end
    endtask

    task automatic doReset(input logic [3:0] c);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_cnt_q", 32'(cnt_q), 0);
        checkOutput("rst_wrap_count", 32'(wrap_count), 0);
        checkOutput("rst_seq_err", 32'(seq_err), 0);
        checkOutput("rst_pulses", 32'({wrap_pulse, match_pulse}), 0);
        checkOutput("rst_state", 32'(dut.state), M_INIT);
        applyStimulus(c, 4'd0, 1'b0, 1'b0, 2);
        reset_n = 1'b1;
    endtask

    initial begin
        int cur;
        logic [3:0] cv;
        logic ce;
        $display("[TB] start, glitch filter=%0d", FILTER);
        reset_n = 1'b0;
        cnt_in  = 4'd0;
        cmp_val = 4'd0;
        cmp_en  = 1'b0;
        err_clr = 1'b0;
        modelReset();

        // Reset with count held at 0; compare enabled on 0 must not fire on load
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b0, 3);
        reset_n = 1'b1;
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b0, 2);
        checkOutput("fill_state_init", 32'(dut.state), M_INIT);
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b0, 1);
        checkOutput("fill_state_track", 32'(dut.state), M_TRACK);
        mp_seen = 0;
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b0, 5);
        checkOutput("hold_no_match", mp_seen, 0);

        // Full sweep 1..15,0 every 5 cycles, compare on 9
        wp_seen = 0;
        mp_seen = 0;
        for (int v = 1; v <= 16; v++) applyStimulus(4'(v), 4'd9, 1'b1, 1'b0, 5);
        checkOutput("sweep_match_count", wp_seen + 16 * mp_seen, 17);
        checkOutput("sweep_wrap_count", 32'(wrap_count), 1);
        checkOutput("sweep_seq_err", 32'(seq_err), 0);

        // Jump 3 -> 7, then 7 -> 8 in FAULT gives no match
        for (int v = 1; v <= 3; v++) applyStimulus(4'(v), 4'd0, 1'b0, 1'b0, 3);
        applyStimulus(4'd7, 4'd0, 1'b0, 1'b0, 4);
        checkOutput("jump_seq_err", 32'(seq_err), 1);
        checkOutput("jump_cnt_q", 32'(cnt_q), 7);
        mp_seen = 0;
        applyStimulus(4'd8, 4'd8, 1'b1, 1'b0, 4);
        checkOutput("fault_no_match", mp_seen, 0);
        checkOutput("fault_cnt_q", 32'(cnt_q), 8);
        applyStimulus(4'd12, 4'd12, 1'b1, 1'b0, 4);
        applyStimulus(4'd12, 4'd12, 1'b1, 1'b1, 1);
        checkOutput("clr_seq_err", 32'(seq_err), 0);
        checkOutput("clr_state", 32'(dut.state), M_INIT);
        mp_seen = 0;
        applyStimulus(4'd12, 4'd12, 1'b1, 1'b0, 3);
        checkOutput("reload_cnt_q", 32'(cnt_q), 12);
        checkOutput("reload_state", 32'(dut.state), M_TRACK);
        checkOutput("reload_no_match", mp_seen, 0);

        // One-cycle ripple glitch 7 -> 6 -> 8
        doReset(4'd7);
        applyStimulus(4'd7, 4'd0, 1'b0, 1'b0, 3 + LAT);
        applyStimulus(4'd6, 4'd0, 1'b0, 1'b0, 1);
        applyStimulus(4'd8, 4'd0, 1'b0, 1'b0, 5);
        checkOutput("glitch_cnt_q", 32'(cnt_q), 8);
        checkOutput("glitch_seq_err", 32'(seq_err), FILTER ? 0 : 1);

        // err_clr coinciding with a new bad jump: error wins
        applyStimulus(4'd2, 4'd0, 1'b0, 1'b0, 4);
        applyStimulus(4'd11, 4'd0, 1'b0, 1'b0, LAT);
        applyStimulus(4'd11, 4'd0, 1'b0, 1'b1, 1);
        checkOutput("clr_vs_err_seq_err", 32'(seq_err), 1);
        checkOutput("clr_vs_err_state", 32'(dut.state), M_FAULT);
        applyStimulus(4'd11, 4'd0, 1'b0, 1'b0, 2);
        applyStimulus(4'd11, 4'd0, 1'b0, 1'b1, 1);
        checkOutput("late_clr_seq_err", 32'(seq_err), 0);
        applyStimulus(4'd11, 4'd0, 1'b0, 1'b0, 2);
        checkOutput("late_clr_state", 32'(dut.state), M_TRACK);

        // 256 full wraps with random hold times and compare settings
        doReset(4'd0);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 5);
        wp_seen = 0;
        for (int w = 0; w < 256; w++) begin
            cv = 4'($urandom_range(0, 15));
            ce = 1'($urandom_range(0, 1));
            for (int v = 1; v <= 16; v++)
                applyStimulus(4'(v), cv, ce, 1'b0, int'($urandom_range(MINH, 3)));
        end
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, LAT);
        checkOutput("wraps_seen", wp_seen, 256);
        checkOutput("wraps_count_rollover", 32'(wrap_count), 0);
        checkOutput("wraps_seq_err", 32'(seq_err), 0);
        for (int v = 1; v <= 21; v++) applyStimulus(4'(v), 4'd0, 1'b0, 1'b0, MINH);
        applyStimulus(4'd5, 4'd0, 1'b0, 1'b0, LAT);
        checkOutput("pre_reset_wrap_count", 32'(wrap_count), 1);
        checkOutput("pre_reset_cnt_q", 32'(cnt_q), 5);

        // Asynchronous reset mid-count
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_cnt_q", 32'(cnt_q), 0);
        checkOutput("async_rst_wrap_count", 32'(wrap_count), 0);
        checkOutput("async_rst_flags", 32'({wrap_pulse, match_pulse, seq_err}), 0);
        modelReset();
        applyStimulus(4'd5, 4'd0, 1'b0, 1'b0, 2);
        reset_n = 1'b1;

        // Randomized mix of steps, jumps, holds and clears
        cur = 5;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) cur = (cur + 1) % 16;
            else cur = int'($urandom_range(0, 15));
            cv = ($urandom_range(0, 1) == 1) ? 4'(cur) : 4'($urandom_range(0, 15));
            applyStimulus(4'(cur), cv, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 5) == 0), int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
